alu_serial_ctrl: RTL

Bit-serial sequencer that time-multiplexes one 1-bit ALU slice to execute a full-width MIPS ALU operation, LSB first, one bit per clock. It latches operands and opcode on a start handshake, drives the slice's operand, carry-in and op inputs each cycle, and accumulates the slice output into a result register. It sits in the low-area datapath variant, in place of the ripple-array ALU, and returns result, zero flag and done pulse to the core control.

---
 rtl/alu_serial_pkg.sv | 31 +++
 rtl/serial_shreg.sv | 27 ++
 rtl/alu_serial_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/alu_serial_pkg.sv
// Shared types for the bit-serial ALU sequencer: opcodes, FSM states and opcode helpers.
package alu_serial_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_XOR = 3'b011,
    OP_ILL = 3'b100,
    OP_NOR = 3'b101,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Arithmetic ops take the slice sum output; logic ops take the slice result mux.
  function automatic logic is_arith(input op_e o);
    return (o == OP_ADD) || (o == OP_SUB) || (o == OP_SLT);
  endfunction

  // Subtract-style ops need carry-in of 1 on bit 0 (two's complement of B).
  function automatic logic is_sub(input op_e o);
    return (o == OP_SUB) || (o == OP_SLT);
  endfunction

endpackage

// File: rtl/serial_shreg.sv
// Right-shifting register with parallel load; LSB leaves first, new bits enter at the MSB.
module serial_shreg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] load_val,
  input  logic             msb_in,
  output logic             lsb_out,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift_en) begin
      q <= {msb_in, q[WIDTH-1:1]};
    end
  end

  assign lsb_out = q[0];

endmodule

// File: rtl/alu_serial_ctrl.sv
// Sequencer driving a 1-bit ALU slice LSB-first for a full-width MIPS ALU op.
// Optional macro ALU_SERIAL_OVF_EN adds an overflow output and a signed-correct SLT.
module alu_serial_ctrl
  import alu_serial_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic             slice_slt_in,
  output logic [2:0]       slice_op,
  input  logic             slice_s,
  input  logic             slice_cout,
  input  logic             slice_result
`ifdef ALU_SERIAL_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q;
  op_e              op_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;

  logic             run;
  logic             accept;
  logic             a_lsb;
  logic             b_lsb;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] a_unused;
  logic [WIDTH-1:0] b_unused;
  logic             acc_lsb_unused;
  logic             cap_bit;
  logic             ovf_bit;
  logic             set_bit;
  logic [WIDTH-1:0] final_res;

  assign run    = (state_q == ST_RUN);
  assign accept = (state_q == ST_IDLE) && start;

  serial_shreg #(.WIDTH(WIDTH)) u_a_sr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .shift_en (run),
    .load_val (a),
    .msb_in   (1'b0),
    .lsb_out  (a_lsb),
    .q        (a_unused)
  );

  serial_shreg #(.WIDTH(WIDTH)) u_b_sr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .shift_en (run),
    .load_val (b),
    .msb_in   (1'b0),
    .lsb_out  (b_lsb),
    .q        (b_unused)
  );

  serial_shreg #(.WIDTH(WIDTH)) u_res_sr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .shift_en (run),
    .load_val ('0),
    .msb_in   (cap_bit),
    .lsb_out  (acc_lsb_unused),
    .q        (acc_q)
  );

  // Slice inputs are quiet outside RUN so the slice sees reset values in IDLE/DONE.
  always_comb begin
    slice_a   = 1'b0;
    slice_b   = 1'b0;
    slice_cin = 1'b0;
    slice_op  = 3'b000;
    if (run) begin
      slice_a   = a_lsb;
      slice_b   = b_lsb;
      slice_cin = (cnt_q == '0) ? is_sub(op_q) : carry_q;
      slice_op  = (op_q == OP_SUB) ? 3'b111 : 3'(op_q);
    end
  end

  assign slice_slt_in = 1'b0;

  // The last slice bit is still combinational at the DONE edge, so splice it in directly.
  assign cap_bit = is_arith(op_q) ? slice_s : slice_result;
  assign ovf_bit = slice_cin ^ slice_cout;
`ifdef ALU_SERIAL_OVF_EN
  assign set_bit = slice_s ^ ovf_bit;
`else
  assign set_bit = slice_s;
`endif
  assign final_res = (op_q == OP_SLT) ? {{(WIDTH-1){1'b0}}, set_bit}
                                      : {cap_bit, acc_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_AND;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      ready    <= 1'b1;
      done     <= 1'b0;
      result   <= '0;
      zero     <= 1'b1;
      illegal  <= 1'b0;
`ifdef ALU_SERIAL_OVF_EN
      overflow <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_q    <= op_e'(op);
            cnt_q   <= '0;
            carry_q <= 1'b0;
            ready   <= 1'b0;
            if (op_e'(op) == OP_ILL) begin
              state_q  <= ST_DONE;
              done     <= 1'b1;
              result   <= '0;
              zero     <= 1'b1;
              illegal  <= 1'b1;
`ifdef ALU_SERIAL_OVF_EN
              overflow <= 1'b0;
`endif
            end else begin
              state_q <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          carry_q <= slice_cout;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            state_q  <= ST_DONE;
            done     <= 1'b1;
            result   <= final_res;
            zero     <= (final_res == '0);
            illegal  <= 1'b0;
`ifdef ALU_SERIAL_OVF_EN
            overflow <= ((op_q == OP_ADD) || (op_q == OP_SUB)) ? ovf_bit : 1'b0;
`endif
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done    <= 1'b0;
          ready   <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          done    <= 1'b0;
          ready   <= 1'b1;
        end
      endcase
    end
  end

endmodule
